rca_pipe_acc: RTL and testbench

Parametrised, pipelined successor to the fixed 32-bit ripple-carry adder. It splits the WIDTH-bit add into registered ripple-carry segments with a valid/ready stream on each side. It adds subtract, accumulate and accumulator-load modes, and returns a WIDTH+GUARD-bit result. It sits between operand-producing datapath blocks and any consumer that needs wide sums or running totals.

---
 rtl/rca_pkg.sv | 28 ++
 rtl/rca_slice.sv | 25 ++
 rtl/rca_pipe_acc.sv | 183 ++++++++++++++++++
 tb/tb_rca_pipe_acc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/accumulator:
// mode encoding, default geometry and the skew-storage offset helpers.
package rca_pkg;

    typedef enum logic [1:0] {
        RCA_ADD  = 2'd0,
        RCA_SUB  = 2'd1,
        RCA_ACC  = 2'd2,
        RCA_LOAD = 2'd3
    } rca_mode_e;

    localparam int RCA_WIDTH  = 32;
    localparam int RCA_CHUNK  = 4;
    localparam int RCA_STAGES = 4;
    localparam int RCA_GUARD  = 8;

    // Stage k keeps only the operand bits not yet added (width - k*seg), so the
    // per-stage operand slices are packed back to back in one flat vector.
    function automatic int rca_op_off(input int width, input int seg, input int k);
        return k * width - seg * k * (k - 1) / 2;
    endfunction

    // Stage k (k >= 1) holds k*seg finished sum bits; offset into the flat vector.
    function automatic int rca_sd_off(input int seg, input int k);
        return seg * k * (k - 1) / 2;
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder slice; chained to form each
// pipeline segment.
module rca_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/rca_pipe_acc.sv
// Pipelined WIDTH-bit ripple-carry adder with subtract, accumulate and load
// modes; valid/ready on both sides, one global stall, result widened by GUARD.
module rca_pipe_acc
    import rca_pkg::*;
#(
    parameter int WIDTH  = RCA_WIDTH,
    parameter int CHUNK  = RCA_CHUNK,
    parameter int STAGES = RCA_STAGES,
    parameter int GUARD  = RCA_GUARD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   cin,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH+GUARD-1:0] sum,
    output logic                   cout,
    output logic                   overflow
);

    localparam int R   = WIDTH + GUARD;
    localparam int SEG = WIDTH / STAGES;
    localparam int NSL = SEG / CHUNK;
    localparam int OPW = rca_op_off(WIDTH, SEG, STAGES);
    localparam int SDW = rca_sd_off(SEG, STAGES + 1);
    localparam int SDF = rca_sd_off(SEG, STAGES);

    if ((WIDTH % (CHUNK * STAGES)) != 0) begin : g_chk_width
        $error("rca_pipe_acc: WIDTH must be a multiple of CHUNK*STAGES");
    end
    if (GUARD < 1) begin : g_chk_guard
        $error("rca_pipe_acc: GUARD must be at least 1");
    end

    logic stall;
    logic is_sub;

    logic [STAGES:0]       vld_pipe_q, vld_pipe_d;
    logic [STAGES:0]       cy_q, cy_d;
    logic [STAGES:0][1:0]  mode_q, mode_d;
    logic [OPW-1:0]        opa_q, opa_d;
    logic [OPW-1:0]        opb_q, opb_d;
    logic [SDW-1:0]        sd_q, sd_d;

    logic                  out_valid_q, out_valid_d;
    logic [R-1:0]          sum_q, sum_d;
    logic                  cout_q, cout_d;
    logic                  ovf_q, ovf_d;
    logic [R-1:0]          acc_q, acc_d;

    logic [WIDTH-1:0]      fin_t;
    logic                  fin_c;
    logic [R-1:0]          ext;
    logic [R:0]            acc_sum;

    // One stall freezes every register, so beats never reorder or collide.
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    // Subtract folds into the adder as a + ~b + 1 at capture time.
    assign is_sub              = (rca_mode_e'(mode) == RCA_SUB);
    assign vld_pipe_d[0]       = in_valid;
    assign cy_d[0]             = is_sub ? 1'b1 : cin;
    assign mode_d[0]           = mode;
    assign opa_d[WIDTH-1:0]    = a;
    assign opb_d[WIDTH-1:0]    = is_sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int OW = WIDTH - k * SEG;
        localparam int OO = rca_op_off(WIDTH, SEG, k);

        logic [OW-1:0]  sa, sb;
        logic [SEG-1:0] ss;

        assign sa = opa_q[OO +: OW];
        assign sb = opb_q[OO +: OW];

        for (genvar j = 0; j < NSL; j++) begin : g_slice
            logic ci, co;
            if (j == 0) begin : g_c0
                assign ci = cy_q[k];
            end else begin : g_cn
                assign ci = g_slice[j-1].co;
            end
            rca_slice #(.W(CHUNK)) u_slice (
                .a   (sa[j*CHUNK +: CHUNK]),
                .b   (sb[j*CHUNK +: CHUNK]),
                .cin (ci),
                .sum (ss[j*CHUNK +: CHUNK]),
                .cout(co)
            );
        end

        assign vld_pipe_d[k+1] = vld_pipe_q[k];
        assign cy_d[k+1]       = g_slice[NSL-1].co;
        assign mode_d[k+1]     = mode_q[k];

        if (k < STAGES - 1) begin : g_skew
            localparam int ON = rca_op_off(WIDTH, SEG, k + 1);
            assign opa_d[ON +: OW-SEG] = sa[OW-1:SEG];
            assign opb_d[ON +: OW-SEG] = sb[OW-1:SEG];
        end

        if (k == 0) begin : g_sd_first
            assign sd_d[SEG-1:0] = ss;
        end else begin : g_sd_rest
            assign sd_d[rca_sd_off(SEG, k + 1) +: (k + 1) * SEG] =
                {ss, sd_q[rca_sd_off(SEG, k) +: k * SEG]};
        end
    end

    assign fin_t = sd_q[SDF +: WIDTH];
    assign fin_c = cy_q[STAGES];

    // Output register doubles as the accumulator stage, so back-to-back ACC
    // beats see the freshly updated acc without any hazard logic.
    always_comb begin
        ext         = R'({fin_c, fin_t});
        acc_sum     = {1'b0, acc_q} + {1'b0, ext};
        out_valid_d = vld_pipe_q[STAGES];
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        if (vld_pipe_q[STAGES]) begin
            cout_d = fin_c;
            case (rca_mode_e'(mode_q[STAGES]))
                RCA_ADD:  sum_d = ext;
                RCA_SUB:  sum_d = {{GUARD{~fin_c}}, fin_t};
                RCA_LOAD: begin
                    acc_d = ext;
                    ovf_d = 1'b0;
                    sum_d = ext;
                end
                RCA_ACC: begin
                    acc_d = acc_sum[R-1:0];
                    ovf_d = ovf_q | acc_sum[R];
                    sum_d = acc_sum[R-1:0];
                end
                default: sum_d = ext;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            cy_q        <= '0;
            mode_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            sd_q        <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else if (!stall) begin
            vld_pipe_q  <= vld_pipe_d;
            cy_q        <= cy_d;
            mode_q      <= mode_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sd_q        <= sd_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_rca_pipe_acc.sv
// Directed bench for rca_pipe_acc: an arithmetic reference model predicts each
// accepted beat, a negedge monitor scores every delivered beat against it.
module tb_rca_pipe_acc;

    localparam int W = 32;
    localparam int R = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [R-1:0]  sum;
    logic          cout;
    logic          overflow;

    rca_pipe_acc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [R-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    exp_t            q[$];
    longint unsigned m_acc = 0;
    bit              m_ovf = 0;
    int              tests = 0;
    int              fails = 0;
    int              cyc = 0;
    int              out_cnt = 0;
    int              last_lat = 0;
    logic [R-1:0]    last_sum = '0;
    logic            last_cout = 1'b0;
    logic            last_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: outputs computed straight from the arithmetic definition.
    task automatic model_push();
        exp_t            e;
        longint unsigned t;
        longint unsigned s;
        t = 64'(a) + 64'(b) + 64'(cin);
        e.cout = t[32];
        e.acc_cyc = cyc;
        case (mode)
            2'd0: e.sum = 40'(t);
            2'd1: begin
                e.sum  = 40'(64'(a) - 64'(b));
                e.cout = (a >= b);
            end
            2'd2: begin
                s = m_acc + t;
                if ((s >> 40) != 0) m_ovf = 1;
                m_acc = s & 64'hFF_FFFF_FFFF;
                e.sum = 40'(m_acc);
            end
            default: begin
                m_acc = t;
                m_ovf = 0;
                e.sum = 40'(m_acc);
            end
        endcase
        e.ovf = m_ovf;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_beat: got sum %0h expected no beat", sum);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sum", 64'(sum), 64'(e.sum));
                    check("cout", 64'(cout), 64'(e.cout));
                    check("overflow", 64'(overflow), 64'(e.ovf));
                    last_sum  = sum;
                    last_cout = cout;
                    last_ovf  = overflow;
                    last_lat  = cyc - e.acc_cyc - 1;
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) model_push();
        end
    end

    task automatic send(input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic c);
        bit ok;
        ok = 0;
        mode = m; a = aa; b = bb; cin = c; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                done = 1;
                break;
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL drain: got %0d beats pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ovf_run();
        send(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 128; i++) send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain();
    endtask

    initial begin
        int cnt0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
        check("add_carry_sum", 64'(last_sum), 64'h01_0000_0000);
        check("add_carry_cout", 64'(last_cout), 64'd1);
        check("latency", 64'(last_lat), 64'd5);

        send(2'd1, 32'd5, 32'd7, 1'b0);
        drain();
        check("sub_borrow_sum", 64'(last_sum), 64'hFF_FFFF_FFFE);
        check("sub_borrow_cout", 64'(last_cout), 64'd0);
        send(2'd1, 32'd7, 32'd5, 1'b0);
        drain();
        check("sub_pos_sum", 64'(last_sum), 64'h00_0000_0002);
        check("sub_pos_cout", 64'(last_cout), 64'd1);

        send(2'd3, 32'd10, 32'd0, 1'b0);
        send(2'd2, 32'd5, 32'd5, 1'b1);
        drain();
        check("load_acc_sum", 64'(last_sum), 64'd21);
        check("load_acc_ovf", 64'(last_ovf), 64'd0);

        ovf_run();
        check("wrap_sum", 64'(last_sum), 64'h01_FFFF_FF7F);
        check("wrap_ovf", 64'(last_ovf), 64'd1);
        send(2'd0, 32'd1, 32'd1, 1'b0);
        drain();
        check("sticky_ovf", 64'(last_ovf), 64'd1);
        check("sticky_sum", 64'(last_sum), 64'd2);
        send(2'd3, 32'd3, 32'd0, 1'b0);
        drain();
        check("load_clears_ovf", 64'(last_ovf), 64'd0);
        check("load_clears_sum", 64'(last_sum), 64'd3);

        cnt0 = out_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) send(2'd0, 32'(i), 32'(i), 1'b0);
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(out_cnt - cnt0), 64'd8);
        check("bp_last_sum", 64'(last_sum), 64'd14);

        ovf_run();
        send(2'd2, 32'd1, 32'd1, 1'b0);
        send(2'd2, 32'd2, 32'd2, 1'b0);
        send(2'd2, 32'd3, 32'd3, 1'b0);
        check("pre_reset_ovf", 64'(overflow), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ovf", 64'(overflow), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        m_acc = 0;
        m_ovf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt0 = out_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_beats", 64'(out_cnt - cnt0), 64'd0);
        send(2'd2, 32'd1, 32'd0, 1'b0);
        drain();
        check("acc_after_rst", 64'(last_sum), 64'd1);
        check("ovf_after_rst", 64'(last_ovf), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
